// File: rtl/ahb_mst_xfer.sv
// rtl/ahb_mst_xfer.sv - AHB burst master moving words between the DMA FIFO and memory
module ahb_mst_xfer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              req_done,
    output logic              xfer_err,
    output logic              hbusreq,
    input  logic              hgrant,
    input  logic              hready,
    input  logic [1:0]        hresp,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hburst,
    output logic [2:0]        hsize,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_pop,
    output logic              fifo_push,
    output logic [DATA_W-1:0] fifo_wdata
);
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [2:0] BURST_FIXED = (BEATS == 4)  ? 3'b011 :
                                         (BEATS == 8)  ? 3'b101 :
                                         (BEATS == 16) ? 3'b111 : 3'b001;
    localparam logic [2:0] BURST_INCR = 3'b001;
    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] TR_SEQ     = 2'b11;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_LAST, S_ERR, S_DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_haddr;
    logic [1:0]        r_htrans;
    logic              r_hwrite;
    logic              r_hbusreq;
    logic              r_req_done;
    logic              r_xfer_err;
    logic              r_incr;
    logic              r_replay;
    logic              r_dp;
    logic [DATA_W-1:0] r_hwdata;
    logic [CNT_W-1:0]  r_cnt;

    logic w_accept;
    logic w_final;
    logic w_fault;
    logic w_pop;
    logic w_push;

    assign w_accept = r_htrans[1] & hready;
    assign w_final  = (r_cnt == CNT_W'(1));
    // First cycle of a two-cycle ERROR/RETRY/SPLIT response on the beat in its data phase
    assign w_fault  = r_dp & ~hready & (hresp != RESP_OKAY);
    // A retried write beat re-drives the word it already holds, so it must not pop again
    assign w_pop    = w_accept & r_hwrite & ~r_replay;
    assign w_push   = r_dp & ~r_hwrite & hready & (hresp == RESP_OKAY);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state    <= S_IDLE;
            r_haddr    <= '0;
            r_htrans   <= TR_IDLE;
            r_hwrite   <= 1'b0;
            r_hbusreq  <= 1'b0;
            r_req_done <= 1'b0;
            r_xfer_err <= 1'b0;
            r_incr     <= 1'b0;
            r_replay   <= 1'b0;
            r_dp       <= 1'b0;
            r_hwdata   <= '0;
            r_cnt      <= '0;
        end else begin
            r_req_done <= 1'b0;
            r_xfer_err <= 1'b0;
            if (r_dp && hready) begin
                r_dp <= 1'b0;
            end
            if (w_accept) begin
                r_dp     <= 1'b1;
                r_haddr  <= r_haddr + ADDR_W'(4);
                r_cnt    <= r_cnt - CNT_W'(1);
                r_replay <= 1'b0;
                if (w_pop) begin
                    r_hwdata <= fifo_rdata;
                end
            end

            if (w_fault) begin
                r_htrans <= TR_IDLE;
                if (hresp == RESP_ERROR) begin
                    r_hbusreq <= 1'b0;
                    r_state   <= S_ERR;
                end else begin
                    // The next beat was never accepted, so stepping back one word lands on the faulted beat
                    r_haddr   <= r_haddr - ADDR_W'(4);
                    r_cnt     <= r_cnt + CNT_W'(1);
                    r_incr    <= 1'b1;
                    r_replay  <= r_hwrite;
                    r_hbusreq <= 1'b1;
                    r_state   <= S_REQ;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (wr_req || rd_req) begin
                            r_hwrite  <= wr_req;
                            r_haddr   <= wr_req ? wr_addr : rd_addr;
                            r_cnt     <= CNT_W'(BEATS);
                            r_incr    <= 1'b0;
                            r_replay  <= 1'b0;
                            r_hbusreq <= 1'b1;
                            r_state   <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (hgrant && hready) begin
                            r_htrans <= TR_NONSEQ;
                            r_state  <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (w_accept) begin
                            if (w_final) begin
                                r_htrans  <= TR_IDLE;
                                r_hbusreq <= 1'b0;
                                r_state   <= S_LAST;
                            end else if (!hgrant) begin
                                r_htrans <= TR_IDLE;
                                r_incr   <= 1'b1;
                                r_state  <= S_REQ;
                            end else begin
                                r_htrans <= TR_SEQ;
                            end
                        end
                    end
                    S_LAST: begin
                        if (r_dp && hready && hresp == RESP_OKAY) begin
                            r_req_done <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                    S_ERR: begin
                        if (hready) begin
                            r_req_done <= 1'b1;
                            r_xfer_err <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign req_done   = r_req_done;
    assign xfer_err   = r_xfer_err;
    assign hbusreq    = r_hbusreq;
    assign haddr      = r_haddr;
    assign htrans     = r_htrans;
    assign hwrite     = r_hwrite;
    assign hburst     = r_incr ? BURST_INCR : BURST_FIXED;
    assign hsize      = 3'b010;
    assign hwdata     = r_hwdata;
    assign fifo_pop   = w_pop;
    assign fifo_push  = w_push;
    assign fifo_wdata = hrdata;
endmodule

// File: tb/tb_ahb_mst_xfer.sv
// tb/tb_ahb_mst_xfer.sv - scoreboard bench for ahb_mst_xfer with a reactive AHB slave/arbiter/FIFO model
module tb_ahb_mst_xfer;
    logic        hclk    = 1'b0;
    logic        hresetn = 1'b0;
    logic        wr_req  = 1'b0;
    logic        rd_req  = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] rd_addr = '0;
    logic        req_done, xfer_err, hbusreq;
    logic        hgrant  = 1'b0;
    logic        hready  = 1'b1;
    logic [1:0]  hresp   = 2'b00;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hburst, hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata     = '0;
    logic [31:0] fifo_rdata = '0;
    logic        fifo_pop, fifo_push;
    logic [31:0] fifo_wdata;

    ahb_mst_xfer #(.ADDR_W(32), .DATA_W(32), .BEATS(4)) dut (
        .hclk(hclk), .hresetn(hresetn), .wr_req(wr_req), .rd_req(rd_req),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .req_done(req_done), .xfer_err(xfer_err),
        .hbusreq(hbusreq), .hgrant(hgrant), .hready(hready), .hresp(hresp),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hburst(hburst), .hsize(hsize),
        .hwdata(hwdata), .hrdata(hrdata), .fifo_rdata(fifo_rdata), .fifo_pop(fifo_pop),
        .fifo_push(fifo_push), .fifo_wdata(fifo_wdata)
    );

    always #5 hclk = ~hclk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [36:0] exp_addr[$];
    logic [31:0] exp_wdata[$];
    logic [31:0] exp_push[$];
    logic [31:0] fifo_q[$];

    int pops = 0, pushes = 0, dones = 0, errs = 0, cyc = 0, last_dp_cyc = 0;
    int grant_delay = 2, gcnt = 0, resp_ph = 0, wait_chk = 0;
    logic        fault_armed = 1'b0, wait_armed = 1'b0, drop_armed = 1'b0;
    logic [1:0]  fault_kind  = 2'b00;
    logic [31:0] fault_addr  = '0, wait_addr = '0, drop_addr = '0;
    logic        dp_valid = 1'b0, dp_write = 1'b0;
    logic [31:0] dp_addr  = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hD000_0000 | a;
    endfunction

    // Slave, arbiter and FIFO model: drive inputs 1ns after the edge, sample 1ns later
    initial begin
        logic        accept;
        logic [31:0] tmp;
        forever begin
            @(posedge hclk);
            cyc++;
            #1;
            if (!hresetn) begin
                dp_valid = 1'b0; resp_ph = 0; gcnt = 0; wait_chk = 0;
                hgrant = 1'b0; hready = 1'b1; hresp = 2'b00;
                continue;
            end
            if (resp_ph == 1) begin
                hready = 1'b1; hresp = fault_kind; resp_ph = 2;
            end else if (fault_armed && dp_valid && dp_addr == fault_addr) begin
                hready = 1'b0; hresp = fault_kind; resp_ph = 1; fault_armed = 1'b0;
            end else if (wait_armed && htrans[1] && haddr == wait_addr) begin
                hready = 1'b0; hresp = 2'b00; wait_armed = 1'b0; wait_chk = 2;
            end else begin
                hready = 1'b1; hresp = 2'b00;
            end
            if (drop_armed && htrans[1] && hready && haddr == drop_addr) begin
                hgrant = 1'b0; gcnt = 0; drop_armed = 1'b0;
            end else if (hbusreq) begin
                gcnt++; hgrant = (gcnt > grant_delay);
            end else begin
                gcnt = 0; hgrant = 1'b0;
            end
            hrdata     = dp_valid ? mem_word(dp_addr) : 32'h0;
            fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
            #1;
            accept = htrans[1] && hready;
            if (wait_chk == 1) begin
                check("wait_haddr_hold", 64'(haddr), 64'(wait_addr));
                wait_chk = 0;
            end else if (wait_chk == 2) begin
                wait_chk = 1;
            end
            if (accept) begin
                check("addr_q_empty", 64'(exp_addr.size() == 0), 64'(0));
                if (exp_addr.size() != 0)
                    check("addr_phase", 64'({htrans, hburst, haddr}), 64'(exp_addr.pop_front()));
            end
            if (dp_valid && hready) begin
                last_dp_cyc = cyc;
                if (resp_ph == 2) begin
                    check("fault_htrans_idle", 64'(htrans), 64'(0));
                    check("fault_no_push", 64'(fifo_push), 64'(0));
                    resp_ph = 0;
                end else if (dp_write) begin
                    check("wdata_q_empty", 64'(exp_wdata.size() == 0), 64'(0));
                    if (exp_wdata.size() != 0)
                        check("hwdata", 64'(hwdata), 64'(exp_wdata.pop_front()));
                end else begin
                    check("read_push", 64'(fifo_push), 64'(1));
                    check("push_q_empty", 64'(exp_push.size() == 0), 64'(0));
                    if (exp_push.size() != 0)
                        check("push_data", 64'(fifo_wdata), 64'(exp_push.pop_front()));
                end
            end
            if (accept) begin
                dp_valid = 1'b1; dp_addr = haddr; dp_write = hwrite;
            end else if (dp_valid && hready) begin
                dp_valid = 1'b0;
            end
            if (fifo_pop) begin
                pops++;
                if (fifo_q.size() != 0) tmp = fifo_q.pop_front();
            end
            if (fifo_push) pushes++;
            if (xfer_err) check("err_with_done", 64'(req_done), 64'(1));
            if (req_done) begin
                dones++;
                if (xfer_err) errs++;
                check("done_latency", 64'(cyc - last_dp_cyc), 64'(1));
            end
        end
    end

    task automatic exp_seg(input logic [31:0] base, input int n, input logic [2:0] burst);
        for (int i = 0; i < n; i++)
            exp_addr.push_back({(i == 0) ? 2'b10 : 2'b11, burst, base + 32'(4 * i)});
    endtask

    task automatic load_fifo(input logic [31:0] w0);
        fifo_q.delete();
        for (int i = 0; i < 4; i++) begin
            fifo_q.push_back(w0 + 32'(i));
            exp_wdata.push_back(w0 + 32'(i));
        end
    endtask

    task automatic load_read(input logic [31:0] base, input int n);
        fifo_q.delete();
        for (int i = 0; i < n; i++) exp_push.push_back(mem_word(base + 32'(4 * i)));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctrl"}, 64'({hbusreq, req_done, xfer_err, fifo_pop, fifo_push, hwrite, htrans}), 64'(0));
        check({tag, "_haddr"}, 64'(haddr), 64'(0));
        check({tag, "_hwdata"}, 64'(hwdata), 64'(0));
        check({tag, "_hsize"}, 64'(hsize), 64'(3'b010));
    endtask

    task automatic run_burst(input string tag, input logic wr, input logic [31:0] addr,
                             input int n_pop, input int n_push, input int n_err);
        int d0, p0, q0, e0;
        d0 = dones; p0 = pops; q0 = pushes; e0 = errs;
        if (wr) begin wr_addr = addr; wr_req = 1'b1; end
        else    begin rd_addr = addr; rd_req = 1'b1; end
        for (int i = 0; i < 300 && dones == d0; i++) begin
            @(posedge hclk); #3;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        repeat (4) @(posedge hclk);
        #3;
        check({tag, "_dones"}, 64'(dones - d0), 64'(1));
        check({tag, "_errs"}, 64'(errs - e0), 64'(n_err));
        check({tag, "_pops"}, 64'(pops - p0), 64'(n_pop));
        check({tag, "_pushes"}, 64'(pushes - q0), 64'(n_push));
        check({tag, "_addr_left"}, 64'(exp_addr.size()), 64'(0));
        check({tag, "_wdata_left"}, 64'(exp_wdata.size()), 64'(0));
        check({tag, "_push_left"}, 64'(exp_push.size()), 64'(0));
        fault_armed = 1'b0; wait_armed = 1'b0; drop_armed = 1'b0;
    endtask

    initial begin
        int d0, p0;
        repeat (3) @(posedge hclk);
        #3;
        check_reset("reset");
        hresetn = 1'b1;
        @(posedge hclk); #3;

        load_fifo(32'hA000_0000); exp_seg(32'h1000, 4, 3'b011);
        run_burst("wr_basic", 1'b1, 32'h1000, 4, 0, 0);

        load_read(32'h2000, 4); exp_seg(32'h2000, 4, 3'b011);
        wait_addr = 32'h2008; wait_armed = 1'b1;
        run_burst("rd_wait", 1'b0, 32'h2000, 0, 4, 0);

        load_fifo(32'hB000_0000); exp_seg(32'h1000, 2, 3'b011); exp_seg(32'h1008, 2, 3'b001);
        drop_addr = 32'h1004; drop_armed = 1'b1;
        run_burst("wr_grant_loss", 1'b1, 32'h1000, 4, 0, 0);

        load_read(32'h2000, 2); exp_seg(32'h2000, 3, 3'b011);
        fault_addr = 32'h2008; fault_kind = 2'b01; fault_armed = 1'b1;
        run_burst("rd_error", 1'b0, 32'h2000, 0, 2, 1);

        load_fifo(32'hC000_0000); exp_seg(32'h1000, 4, 3'b011); exp_seg(32'h100C, 1, 3'b001);
        fault_addr = 32'h100C; fault_kind = 2'b10; fault_armed = 1'b1;
        run_burst("wr_retry", 1'b1, 32'h1000, 4, 0, 0);

        load_fifo(32'hE000_0000); exp_seg(32'h1000, 4, 3'b011);
        d0 = dones; p0 = pops;
        wr_addr = 32'h1000; wr_req = 1'b1;
        for (int i = 0; i < 100 && pops < p0 + 2; i++) begin
            @(posedge hclk); #3;
        end
        check("rst_mid_pops", 64'(pops - p0), 64'(2));
        hresetn = 1'b0;
        #1;
        check_reset("rst_mid");
        wr_req = 1'b0;
        exp_addr.delete(); exp_wdata.delete(); fifo_q.delete();
        repeat (2) @(posedge hclk);
        #3;
        hresetn = 1'b1;
        repeat (3) @(posedge hclk);
        #3;
        check("rst_no_done", 64'(dones - d0), 64'(0));

        load_fifo(32'hF000_0000); exp_seg(32'h5000, 4, 3'b011);
        run_burst("wr_after_rst", 1'b1, 32'h5000, 4, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
